// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// One picorv32-style native memory bus link (valid/ready/addr/wdata/wstrb/rdata).
//   master modport : drives valid/addr/wdata/wstrb, receives ready/rdata
//   slave  modport : receives valid/addr/wdata/wstrb, drives ready/rdata
// wstrb == 0 marks a read; ready is a one-cycle completion pulse and rdata is
// only meaningful while ready is high.
interface mem_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-master round-robin arbiter for the native memory bus, with a watchdog
// that force-completes transactions the slave never acknowledges.
//   clk     : system clock, all state on the rising edge
//   rst     : asynchronous active-high reset
//   m0, m1  : slave-side links towards the two bus masters (CPU, DMA)
//   s       : master-side link towards the decode / chip-select fabric
//   owner   : currently granted master (holds its value while idle)
//   timeout : one-cycle pulse when the watchdog forces a completion
// Parameters:
//   TIMEOUT      : BUSY cycles without s.ready before forced completion, 0 = off
//   TIMEOUT_DATA : read data handed to the owner on a forced completion
module mem_arbiter #(
    parameter int          TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    mem_arbiter_if.master s,
    output logic          owner,
    output logic          timeout
);

    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic        busy;
    logic        own_valid;
    logic        done_ok;
    logic        done_wd;
    logic        abort;
    logic        grant;
    logic [31:0] resp_data;

    // Completion / abort decode. A completion needs the owner still requesting;
    // s.ready wins over the watchdog when both land in the same cycle.
    always_comb begin
        busy      = (state_q == ST_BUSY);
        own_valid = owner_q ? m1.valid : m0.valid;
        done_ok   = busy && own_valid && s.ready;
        done_wd   = busy && own_valid && !s.ready && WD_EN && (cnt_q == CNT_LAST);
        abort     = busy && !own_valid;
        resp_data = done_wd ? TIMEOUT_DATA : s.rdata;
    end

    // Fabric side: only the owner's signals are forwarded; s.valid is gated
    // by state so nothing reaches the fabric during the arbitration cycle.
    assign s.valid = busy && own_valid;
    assign s.addr  = owner_q ? m1.addr  : m0.addr;
    assign s.wdata = owner_q ? m1.wdata : m0.wdata;
    assign s.wstrb = owner_q ? m1.wstrb : m0.wstrb;

    // Master side: the non-owner always sees ready=0 and rdata=0.
    assign m0.ready = (done_ok || done_wd) && !owner_q;
    assign m1.ready = (done_ok || done_wd) &&  owner_q;
    assign m0.rdata = owner_q ? 32'h0 : resp_data;
    assign m1.rdata = owner_q ? resp_data : 32'h0;

    assign owner   = owner_q;
    assign timeout = done_wd;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0.valid || m1.valid) begin
                    // On a tie the master not served last wins; otherwise
                    // whichever master is requesting.
                    grant   = (m0.valid && m1.valid) ? !last_q : m1.valid;
                    owner_d = grant;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done_ok || done_wd || abort) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;    // so m0 wins the first tie after reset
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios plus a randomized round-robin run for mem_arbiter
// (TIMEOUT=4). Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_mem_arbiter;

    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic owner;
    logic timeout;

    always #5 clk = ~clk;

    mem_arbiter_if m0_bus ();
    mem_arbiter_if m1_bus ();
    mem_arbiter_if s_bus ();

    mem_arbiter #(.TIMEOUT(4), .TIMEOUT_DATA(TO_DATA)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .owner   (owner),
        .timeout (timeout)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        m0_bus.valid = 1'b0; m0_bus.addr = 32'h0; m0_bus.wdata = 32'h0; m0_bus.wstrb = 4'h0;
        m1_bus.valid = 1'b0; m1_bus.addr = 32'h0; m1_bus.wdata = 32'h0; m1_bus.wstrb = 4'h0;
        s_bus.ready  = 1'b0; s_bus.rdata = 32'h0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m0_bus.valid = 1'b1; m1_bus.valid = 1'b1; s_bus.ready = 1'b1;
        @(negedge clk);
        vectors++; if (s_bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_s_valid got=%b exp=0", s_bus.valid); end
        vectors++; if (m0_bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_m0_ready got=%b exp=0", m0_bus.ready); end
        vectors++; if (m1_bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_m1_ready got=%b exp=0", m1_bus.ready); end
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL reset_owner got=%b exp=0", owner); end
        $display("reset: outputs quiet with all inputs active");
        do_reset();
    endtask

    task automatic test_single_read;
        do_reset();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_1004; m0_bus.wstrb = 4'h0;
        @(negedge clk);   // cycle 0: arbitration
        vectors++; if (s_bus.valid !== 1'b0) begin miscompares++; $display("FAIL single_c0_s_valid got=%b exp=0", s_bus.valid); end
        tick();
        @(negedge clk);   // cycle 1: first BUSY cycle
        vectors++; if (s_bus.valid !== 1'b1) begin miscompares++; $display("FAIL single_c1_s_valid got=%b exp=1", s_bus.valid); end
        vectors++; if (s_bus.addr !== 32'h0000_1004) begin miscompares++; $display("FAIL single_s_addr got=%h exp=00001004", s_bus.addr); end
        vectors++; if (m0_bus.ready !== 1'b0) begin miscompares++; $display("FAIL single_c1_m0_ready got=%b exp=0", m0_bus.ready); end
        tick();
        s_bus.ready = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);   // cycle 2: slave acknowledges
        vectors++; if (m0_bus.ready !== 1'b1) begin miscompares++; $display("FAIL single_m0_ready got=%b exp=1", m0_bus.ready); end
        vectors++; if (m0_bus.rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL single_m0_rdata got=%h exp=cafef00d", m0_bus.rdata); end
        vectors++; if (m1_bus.ready !== 1'b0) begin miscompares++; $display("FAIL single_m1_ready got=%b exp=0", m1_bus.ready); end
        vectors++; if (m1_bus.rdata !== 32'h0) begin miscompares++; $display("FAIL single_m1_rdata got=%h exp=0", m1_bus.rdata); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL single_owner got=%b exp=0", owner); end
        tick();
        idle_all();
        @(negedge clk);
        vectors++; if (m0_bus.ready !== 1'b0) begin miscompares++; $display("FAIL single_after_m0_ready got=%b exp=0", m0_bus.ready); end
        $display("single read: m0 addr=00001004 rdata=cafef00d");
    endtask

    task automatic test_contention;
        logic exp_done;
        logic exp_who;
        do_reset();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_0100;
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_0200;
        s_bus.ready = 1'b1; s_bus.rdata = 32'h1111_0000;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            exp_done = (cyc % 2) == 1;
            exp_who  = ((cyc / 2) % 2) == 1;
            vectors++; if (m0_bus.ready !== (exp_done && !exp_who)) begin miscompares++; $display("FAIL rr_m0_ready cyc=%0d got=%b exp=%b", cyc, m0_bus.ready, exp_done && !exp_who); end
            vectors++; if (m1_bus.ready !== (exp_done && exp_who)) begin miscompares++; $display("FAIL rr_m1_ready cyc=%0d got=%b exp=%b", cyc, m1_bus.ready, exp_done && exp_who); end
            if (exp_done) begin
                vectors++; if (owner !== exp_who) begin miscompares++; $display("FAIL rr_owner cyc=%0d got=%b exp=%b", cyc, owner, exp_who); end
                vectors++; if (s_bus.addr !== (exp_who ? 32'h200 : 32'h100)) begin miscompares++; $display("FAIL rr_s_addr cyc=%0d got=%h exp=%h", cyc, s_bus.addr, exp_who ? 32'h200 : 32'h100); end
                $display("contention: cycle %0d completion for m%0d", cyc, exp_who);
            end
            tick();
        end
        idle_all();
    endtask

    task automatic test_write_mux;
        do_reset();
        m0_bus.valid = 1'b0; m0_bus.addr = 32'hFFFF_0000; m0_bus.wdata = 32'h1234_5678; m0_bus.wstrb = 4'hF;
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_3000; m1_bus.wdata = 32'h0000_00A5; m1_bus.wstrb = 4'b0001;
        tick();
        @(negedge clk);
        vectors++; if (owner !== 1'b1) begin miscompares++; $display("FAIL wr_owner got=%b exp=1", owner); end
        vectors++; if (s_bus.valid !== 1'b1) begin miscompares++; $display("FAIL wr_s_valid got=%b exp=1", s_bus.valid); end
        vectors++; if (s_bus.addr !== 32'h0000_3000) begin miscompares++; $display("FAIL wr_s_addr got=%h exp=00003000", s_bus.addr); end
        vectors++; if (s_bus.wdata !== 32'h0000_00A5) begin miscompares++; $display("FAIL wr_s_wdata got=%h exp=000000a5", s_bus.wdata); end
        vectors++; if (s_bus.wstrb !== 4'b0001) begin miscompares++; $display("FAIL wr_s_wstrb got=%h exp=1", s_bus.wstrb); end
        vectors++; if (m1_bus.ready !== 1'b0) begin miscompares++; $display("FAIL wr_early_m1_ready got=%b exp=0", m1_bus.ready); end
        tick();
        s_bus.ready = 1'b1;
        @(negedge clk);
        vectors++; if (m1_bus.ready !== 1'b1) begin miscompares++; $display("FAIL wr_m1_ready got=%b exp=1", m1_bus.ready); end
        vectors++; if (m0_bus.ready !== 1'b0) begin miscompares++; $display("FAIL wr_m0_ready got=%b exp=0", m0_bus.ready); end
        tick();
        idle_all();
        @(negedge clk);
        vectors++; if (m1_bus.ready !== 1'b0) begin miscompares++; $display("FAIL wr_second_m1_ready got=%b exp=0", m1_bus.ready); end
        $display("write mux: m1 addr=00003000 wdata=000000a5 wstrb=1");
    endtask

    task automatic test_watchdog(input bit ack_last);
        do_reset();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_9000; m0_bus.wstrb = 4'h0;
        s_bus.rdata = 32'h1357_9BDF;
        tick();
        for (int b = 1; b <= 4; b++) begin
            s_bus.ready = (b == 4) && ack_last;
            @(negedge clk);
            if (b < 4) begin
                vectors++; if (m0_bus.ready !== 1'b0) begin miscompares++; $display("FAIL wd_early_ready busy=%0d got=%b exp=0", b, m0_bus.ready); end
                vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL wd_early_timeout busy=%0d got=%b exp=0", b, timeout); end
            end else begin
                vectors++; if (m0_bus.ready !== 1'b1) begin miscompares++; $display("FAIL wd_ready ack=%0b got=%b exp=1", ack_last, m0_bus.ready); end
                vectors++; if (timeout !== !ack_last) begin miscompares++; $display("FAIL wd_timeout ack=%0b got=%b exp=%b", ack_last, timeout, !ack_last); end
                vectors++; if (m0_bus.rdata !== (ack_last ? 32'h1357_9BDF : TO_DATA)) begin miscompares++; $display("FAIL wd_rdata ack=%0b got=%h exp=%h", ack_last, m0_bus.rdata, ack_last ? 32'h1357_9BDF : TO_DATA); end
            end
            tick();
        end
        idle_all();
        @(negedge clk);
        vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL wd_after_timeout got=%b exp=0", timeout); end
        $display("watchdog: m0 addr=00009000 ack_in_last_cycle=%0b", ack_last);
    endtask

    task automatic test_reset_mid;
        do_reset();
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_4000;
        tick();
        @(negedge clk);
        vectors++; if (owner !== 1'b1) begin miscompares++; $display("FAIL rmid_owner_before got=%b exp=1", owner); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        s_bus.ready = 1'b1;
        #1;
        vectors++; if (s_bus.valid !== 1'b0) begin miscompares++; $display("FAIL rmid_s_valid got=%b exp=0", s_bus.valid); end
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL rmid_owner got=%b exp=0", owner); end
        vectors++; if (m1_bus.ready !== 1'b0) begin miscompares++; $display("FAIL rmid_m1_ready got=%b exp=0", m1_bus.ready); end
        m0_bus.valid = 1'b1;
        tick();
        @(negedge clk);
        vectors++; if (m1_bus.ready !== 1'b0) begin miscompares++; $display("FAIL rmid_hold_m1_ready got=%b exp=0", m1_bus.ready); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if ((m0_bus.ready | m1_bus.ready) !== 1'b0) begin miscompares++; $display("FAIL rmid_arb_ready got=%b exp=0", m0_bus.ready | m1_bus.ready); end
        tick();
        @(negedge clk);
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL rmid_first_owner got=%b exp=0", owner); end
        vectors++; if (m0_bus.ready !== 1'b1) begin miscompares++; $display("FAIL rmid_m0_ready got=%b exp=1", m0_bus.ready); end
        tick();
        idle_all();
        $display("reset mid-transaction: m1 abandoned, m0 granted first after release");
    endtask

    task automatic test_abort;
        do_reset();
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h0000_5000;
        tick();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h0000_6000;
        @(negedge clk);
        vectors++; if (s_bus.valid !== 1'b1) begin miscompares++; $display("FAIL abort_busy1_s_valid got=%b exp=1", s_bus.valid); end
        tick();
        m1_bus.valid = 1'b0;
        @(negedge clk);
        vectors++; if (s_bus.valid !== 1'b0) begin miscompares++; $display("FAIL abort_s_valid got=%b exp=0", s_bus.valid); end
        vectors++; if ((m0_bus.ready | m1_bus.ready) !== 1'b0) begin miscompares++; $display("FAIL abort_ready got=%b exp=0", m0_bus.ready | m1_bus.ready); end
        tick();
        @(negedge clk);
        vectors++; if (s_bus.valid !== 1'b0) begin miscompares++; $display("FAIL abort_idle_s_valid got=%b exp=0", s_bus.valid); end
        tick();
        @(negedge clk);
        vectors++; if (owner !== 1'b0) begin miscompares++; $display("FAIL abort_next_owner got=%b exp=0", owner); end
        vectors++; if (s_bus.addr !== 32'h0000_6000) begin miscompares++; $display("FAIL abort_next_addr got=%h exp=00006000", s_bus.addr); end
        tick();
        idle_all();
        tick();
        $display("abort: m1 dropped valid, m0 granted next");
    endtask

    task automatic drive_heads;
        m0_bus.valid = (q0.size() > 0);
        if (q0.size() > 0) begin m0_bus.addr = q0[0].addr; m0_bus.wdata = q0[0].wdata; m0_bus.wstrb = q0[0].wstrb; end
        m1_bus.valid = (q1.size() > 0);
        if (q1.size() > 0) begin m1_bus.addr = q1[0].addr; m1_bus.wdata = q1[0].wdata; m1_bus.wstrb = q1[0].wstrb; end
    endtask

    // Transaction-level model: each completion must go to the master picked by
    // round-robin among those with pending work; bits [6:4] of the address set
    // the slave's wait states, and 4+ wait states must end in a watchdog reply.
    task automatic test_random;
        txn_t        t;
        logic        model_last;
        logic        exp_who;
        logic        got_who;
        logic        exp_to;
        logic [31:0] exp_data;
        logic [31:0] got_data;
        int          wait_cnt;
        int          n0;
        int          n1;
        do_reset();
        q0.delete(); q1.delete();
        n0 = $urandom_range(4, 12);
        n1 = $urandom_range(4, 12);
        for (int i = 0; i < n0 + n1; i++) begin
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (i < n0) q0.push_back(t); else q1.push_back(t);
        end
        model_last = 1'b1;
        wait_cnt   = 0;
        for (int cyc = 0; cyc < 3000 && (q0.size() > 0 || q1.size() > 0); cyc++) begin
            drive_heads();
            #1;
            if (s_bus.valid) begin
                s_bus.ready = (wait_cnt == int'(s_bus.addr[6:4]));
                s_bus.rdata = slave_data(s_bus.addr);
            end else begin
                s_bus.ready = 1'b0;
                s_bus.rdata = $urandom;
            end
            @(negedge clk);
            if (m0_bus.ready || m1_bus.ready) begin
                exp_who  = (q0.size() > 0 && q1.size() > 0) ? !model_last : (q1.size() > 0);
                t        = exp_who ? q1[0] : q0[0];
                exp_to   = (t.addr[6:4] >= 3'd4);
                exp_data = exp_to ? TO_DATA : slave_data(t.addr);
                got_who  = m1_bus.ready;
                got_data = got_who ? m1_bus.rdata : m0_bus.rdata;
                vectors++; if ((m0_bus.ready && m1_bus.ready) || got_who !== exp_who) begin miscompares++; $display("FAIL rnd_grant got=m0:%b,m1:%b exp=m%0d", m0_bus.ready, m1_bus.ready, exp_who); end
                vectors++; if (got_data !== exp_data) begin miscompares++; $display("FAIL rnd_rdata m%0d addr=%h got=%h exp=%h", exp_who, t.addr, got_data, exp_data); end
                vectors++; if (timeout !== exp_to) begin miscompares++; $display("FAIL rnd_timeout addr=%h got=%b exp=%b", t.addr, timeout, exp_to); end
                if (!exp_to) begin
                    vectors++; if (s_bus.addr !== t.addr || s_bus.wdata !== t.wdata || s_bus.wstrb !== t.wstrb) begin miscompares++; $display("FAIL rnd_s_bus got=%h/%h/%h exp=%h/%h/%h", s_bus.addr, s_bus.wdata, s_bus.wstrb, t.addr, t.wdata, t.wstrb); end
                end
                $display("txn m%0d addr=%h wstrb=%h rdata=%h timeout=%0b", exp_who, t.addr, t.wstrb, got_data, timeout);
                model_last = exp_who;
                if (exp_who) void'(q1.pop_front()); else void'(q0.pop_front());
                wait_cnt = 0;
            end else begin
                vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL rnd_idle_timeout cyc=%0d got=%b exp=0", cyc, timeout); end
                wait_cnt = s_bus.valid ? wait_cnt + 1 : 0;
            end
            tick();
        end
        vectors++;
        if (q0.size() > 0 || q1.size() > 0) begin
            miscompares++;
            $display("FAIL rnd_budget pending got=%0d exp=0", q0.size() + q1.size());
        end
        idle_all();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_read();
        test_contention();
        test_write_mux();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_reset_mid();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
